// File: rtl/subtree_rr_scheduler.sv
// subtree_rr_scheduler: round-robin one-hot grant of a shared activation slot among NUM_CHILD children.
// Optional grant watchdog is compiled in when SCHED_WDOG_EN is defined.
module subtree_rr_scheduler #(
  parameter int NUM_CHILD   = 5,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CHILD-1:0] req,
  input  logic [NUM_CHILD-1:0] done,
  output logic [NUM_CHILD-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int unsigned NC = NUM_CHILD;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_CHILD-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic                 r_busy, w_busy_nxt;

  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic [NUM_CHILD-1:0] w_win_oh;
  logic [IDX_W-1:0]     w_win_inc;
  logic                 w_done_hit;

`ifdef SCHED_WDOG_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [HOLD_W-1:0]    r_hold, w_hold_nxt;
  logic                 r_tpulse, w_tpulse_nxt;
`endif

  // Winner is the requester with the smallest rotational distance from r_ptr.
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best;
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    p        = 32'(r_ptr);
    d        = 0;
    best     = 0;
    for (int unsigned i = 0; i < NC; i++) begin
      d = (i >= p) ? (i - p) : (i + NC - p);
      if (req[i] && (!w_found || d < best)) begin
        w_found     = 1'b1;
        best        = d;
        w_win       = IDX_W'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  assign w_win_inc  = (w_win == IDX_W'(NUM_CHILD - 1)) ? '0 : w_win + IDX_W'(1);
  assign w_done_hit = |(done & r_grant);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_idx_nxt    = r_idx;
    w_ptr_nxt    = r_ptr;
    w_busy_nxt   = r_busy;
`ifdef SCHED_WDOG_EN
    w_hold_nxt   = r_hold;
    w_tpulse_nxt = 1'b0;
`endif
    case (r_state)
      S_GRANT: begin
        if (w_done_hit) begin
          w_state_nxt = S_RELEASE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
`ifdef SCHED_WDOG_EN
        else if (r_hold == HOLD_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt  = S_RELEASE;
          w_grant_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_tpulse_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = w_win_oh;
          w_idx_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_win_inc;
`ifdef SCHED_WDOG_EN
          w_hold_nxt  = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_busy   <= 1'b0;
`ifdef SCHED_WDOG_EN
      r_hold   <= '0;
      r_tpulse <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_idx    <= w_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_busy   <= w_busy_nxt;
`ifdef SCHED_WDOG_EN
      r_hold   <= w_hold_nxt;
      r_tpulse <= w_tpulse_nxt;
`endif
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign busy      = r_busy;
`ifdef SCHED_WDOG_EN
  assign timeout_pulse = r_tpulse;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Bench for subtree_rr_scheduler: directed scenarios plus randomized traffic against a round-robin model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_subtree_rr_scheduler;

  localparam int N = 5;
  localparam int W = 3;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         busy;
  logic         timeout_pulse;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  subtree_rr_scheduler #(.NUM_CHILD(N), .IDX_W(W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
    .grant_idx(grant_idx), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference: scan children starting at the pointer, wrapping; -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || grant_idx !== '0 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b idx=%0d busy=%b tp=%b, need all zero", grant, grant_idx, busy, timeout_pulse);
    end
    do_reset();
    req = 5'b00100;
    @(negedge clk);
    checks++;
    if (grant !== 5'b00100 || grant_idx !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b idx=%0d busy=%b, need 00100 2 1", grant, grant_idx, busy);
    end
    done = 5'b00100;
    req  = '0;
    @(negedge clk);
    done = '0;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b, need 00000 0", grant, busy);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] g;
    do_reset();
    req = '1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      g = onehot(k % N);
      checks++;
      if (grant !== g || grant_idx !== W'(k % N) || busy !== 1'b1) begin
        errors++;
        $display("FAIL fair_grant%0d: grant=%b idx=%0d busy=%b, need %b %0d 1", k, grant, grant_idx, busy, g, k % N);
      end
      @(negedge clk);
      checks++;
      if (grant !== g) begin
        errors++;
        $display("FAIL fair_hold%0d: grant=%b, need %b", k, grant, g);
      end
      done = g;
      @(negedge clk);
      done = '0;
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL fair_gap%0d: grant=%b busy=%b, need 00000 0", k, grant, busy);
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic test_foreign_done();
    do_reset();
    req = 5'b00010;
    @(negedge clk);
    checks++;
    if (grant !== 5'b00010 || grant_idx !== 3'd1) begin
      errors++;
      $display("FAIL foreign_grant: grant=%b idx=%0d, need 00010 1", grant, grant_idx);
    end
    req  = '0;
    done = 5'b01000;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      done = '0;
      checks++;
      if (grant !== 5'b00010 || busy !== 1'b1) begin
        errors++;
        $display("FAIL foreign_hold%0d: grant=%b busy=%b, need 00010 1", j, grant, busy);
      end
    end
    done = 5'b00010;
    @(negedge clk);
    done = '0;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL foreign_release: grant=%b busy=%b, need 00000 0", grant, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 5'b10000;
    @(negedge clk);
    checks++;
    if (grant !== 5'b10000 || grant_idx !== 3'd4) begin
      errors++;
      $display("FAIL wrap_first: grant=%b idx=%0d, need 10000 4", grant, grant_idx);
    end
    done = 5'b10000;
    req  = 5'b10001;
    @(negedge clk);
    done = '0;
    @(negedge clk);
    checks++;
    if (grant !== 5'b00001 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to0: grant=%b idx=%0d, need 00001 0", grant, grant_idx);
    end
    done = 5'b00001;
    @(negedge clk);
    done = '0;
    @(negedge clk);
    checks++;
    if (grant !== 5'b10000 || grant_idx !== 3'd4) begin
      errors++;
      $display("FAIL wrap_to4: grant=%b idx=%0d, need 10000 4", grant, grant_idx);
    end
    done = 5'b10000;
    req  = '0;
    @(negedge clk);
    done = '0;
  endtask

`ifdef SCHED_WDOG_EN
  task automatic test_watchdog();
    int cnt;
    do_reset();
    req = 5'b00001;
    @(negedge clk);
    req = '0;
    cnt = 0;
    for (int c = 0; c < 40 && grant !== '0; c++) begin
      cnt++;
      if (timeout_pulse !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL wdog_early_pulse: tp=%b during grant cycle %0d, need 0", timeout_pulse, cnt);
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != T || timeout_pulse !== 1'b1) begin
      errors++;
      $display("FAIL wdog_abort: held=%0d tp=%b, need %0d 1", cnt, timeout_pulse, T);
    end
    @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wdog_pulse_len: tp=%b, need 0", timeout_pulse);
    end
    req = 5'b00001;
    @(negedge clk);
    req = '0;
    for (int j = 2; j <= T; j++) @(negedge clk);
    checks++;
    if (grant !== 5'b00001) begin
      errors++;
      $display("FAIL wdog_last_cycle: grant=%b, need 00001", grant);
    end
    done = 5'b00001;
    @(negedge clk);
    done = '0;
    checks++;
    if (grant !== '0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wdog_done_wins: grant=%b tp=%b, need 00000 0", grant, timeout_pulse);
    end
  endtask
`else
  task automatic test_watchdog();
    do_reset();
    req = 5'b00001;
    @(negedge clk);
    req = '0;
    repeat (40) @(negedge clk);
    checks++;
    if (grant !== 5'b00001 || busy !== 1'b1 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL no_wdog_hold: grant=%b busy=%b tp=%b, need 00001 1 0", grant, busy, timeout_pulse);
    end
    done = 5'b00001;
    @(negedge clk);
    done = '0;
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    req = 5'b01000;
    @(negedge clk);
    checks++;
    if (grant !== 5'b01000 || grant_idx !== 3'd3) begin
      errors++;
      $display("FAIL arst_grant: grant=%b idx=%0d, need 01000 3", grant, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop: grant=%b busy=%b, need 00000 0", grant, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = '1;
    @(negedge clk);
    checks++;
    if (grant !== 5'b00001 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL arst_ptr: grant=%b idx=%0d, need 00001 0", grant, grant_idx);
    end
    done = 5'b00001;
    req  = '0;
    @(negedge clk);
    done = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] g;
    int           e;
    int           h;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      done = '0;
      r    = N'($urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      req = r;
      @(negedge clk);
      e = pick(r, m_ptr);
      if (e < 0) begin
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle%0d: grant=%b busy=%b, need 00000 0", it, grant, busy);
        end
        continue;
      end
      g = onehot(e);
      m_ptr = (e + 1) % N;
      checks++;
      if (grant !== g || grant_idx !== W'(e) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_grant%0d: req=%b grant=%b idx=%0d, need %b %0d", it, r, grant, grant_idx, g, e);
      end
      h = $urandom_range(0, 4);
      for (int j = 0; j < h; j++) begin
        req  = N'($urandom);
        done = N'($urandom) & ~g;
        @(negedge clk);
        checks++;
        if (grant !== g || busy !== 1'b1) begin
          errors++;
          $display("FAIL rnd_hold%0d: grant=%b busy=%b, need %b 1", it, grant, busy, g);
        end
      end
      req  = N'($urandom);
      done = g | (N'($urandom) & ~g);
      @(negedge clk);
      checks++;
      if (grant !== '0 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
        errors++;
        $display("FAIL rnd_release%0d: grant=%b busy=%b tp=%b, need 00000 0 0", it, grant, busy, timeout_pulse);
      end
    end
    done = '0;
    req  = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_foreign_done();
    test_wrap();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
